// File: rtl/dataout_sink.sv
// dataout_sink: NoC ejection-port sink that captures flits into a FIFO and keeps
// receive, misroute, sequence-error and burst-window statistics.
module dataout_sink #(
   parameter logic [3:0] NODE_ID  = 4'd0,
   parameter int         DEPTH    = 32,
   parameter int         EXPECTED = 30
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic [19:0]              datain,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     rd_en,
   output logic [19:0]              rd_data,
   output logic                     rd_valid,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [15:0]              rx_count,
   output logic [15:0]              misroute_count,
   output logic [15:0]              seq_err_count,
   output logic [15:0]              window_cycles,
   output logic                     done
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [15:0] LAST = 16'(EXPECTED - 1);
   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
   state_t state, state_n;
   logic [19:0] mem [DEPTH];
   logic [7:0] last_seq [16];
   logic [15:0] seen, window_n;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [3:0] src, dest;
   logic [7:0] seq;
   logic push, pop, mis, err;
   function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
      return (en && v != 16'hFFFF) ? v + 16'd1 : v;
   endfunction
   assign src      = datain[15:12];
   assign seq      = datain[11:4];
   assign dest     = datain[3:0];
   assign in_ready = fifo_count != FULL;
   assign push     = in_valid && in_ready && !clr;
   assign pop      = rd_en && fifo_count != '0 && !clr;
   assign mis      = dest != NODE_ID;
   assign err      = push && !mis && seen[src] && seq != last_seq[src] + 8'd1;
   assign done     = state == FIN;
   always_comb begin
      state_n  = state;
      window_n = window_cycles;
      if (state == IDLE && push) begin
         window_n = 16'd1;
         state_n  = EXPECTED == 1 ? FIN : RUN;
      end else if (state == RUN) begin
         window_n = sat_inc(window_cycles, 1'b1);
         state_n  = (push && rx_count == LAST) ? FIN : RUN;
      end
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state         <= IDLE;
         window_cycles <= '0;
      end else if (clr) begin
         state         <= IDLE;
         window_cycles <= '0;
      end else begin
         state         <= state_n;
         window_cycles <= window_n;
      end
   // Only reset clears the storage; clr just rewinds the pointers.
   always_ff @(posedge clk or negedge rst)
      if (!rst) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      else if (push) mem[wr_ptr] <= datain;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         rd_data    <= '0;
         rd_valid   <= 1'b0;
      end else if (clr) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         rd_data    <= '0;
         rd_valid   <= 1'b0;
      end else begin
         wr_ptr     <= wr_ptr + AW'(push);
         rd_ptr     <= rd_ptr + AW'(pop);
         fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
         rd_valid   <= pop;
         if (pop) rd_data <= mem[rd_ptr];
      end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         rx_count       <= '0;
         misroute_count <= '0;
         seq_err_count  <= '0;
         seen           <= '0;
      end else if (clr) begin
         rx_count       <= '0;
         misroute_count <= '0;
         seq_err_count  <= '0;
         seen           <= '0;
      end else begin
         rx_count       <= sat_inc(rx_count, push);
         misroute_count <= sat_inc(misroute_count, push && mis);
         seq_err_count  <= sat_inc(seq_err_count, err);
         if (push && !mis) seen[src] <= 1'b1;
      end
   // Entries are only trusted once their seen bit is set, so no reset needed.
   always_ff @(posedge clk)
      if (push && !mis) last_seq[src] <= seq;
endmodule
